fir_hls_sdiv_26s_8ns_19_seq: RTL
================================

Name: fir_hls_sdiv_26s_8ns_19_seq

Overview:
- Sequential signed-by-unsigned restoring divider; the inverse of the FIR's signed×unsigned coefficient multiply.
- Takes a 26-bit signed accumulator value and an 8-bit unsigned gain/decimation factor and returns a saturated 19-bit signed quotient plus a signed remainder.
- Sits after the direct-form FIR accumulator in the multirate chain and normalises output gain.
- Iterative, one quotient bit per cycle, constant latency, valid/ready on both sides.

Parameters:
- DIVIDEND_WIDTH, 26, signed dividend width.
- DIVISOR_WIDTH, 8, unsigned divisor width.
- QUOTIENT_WIDTH, 19, signed quotient width; result saturates to this range.

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_WIDTH  signed two's-complement dividend.
- divisor  in  DIVISOR_WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
- remainder  out  DIVISOR_WIDTH+1  signed remainder; sign follows the dividend.
- ovf  out  1  quotient saturated (divisor nonzero).
- div_zero  out  1  divisor was 0.

Behaviour:
- Reset (ap_rst_n low, async): state=IDLE, out_valid=0, in_ready=0, quotient=0, remainder=0, ovf=0, div_zero=0, iteration counter=0.
- in_ready is 1 in the first cycle after reset release.
- States: IDLE, CALC, FIX, OUT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch sign(dividend), |dividend| as a DIVIDEND_WIDTH-bit unsigned value (|-2^25| = 2^25 fits), and the divisor.
  - Clear the partial remainder, load counter=DIVIDEND_WIDTH, go to CALC. in_ready drops the next cycle.
- CALC:
  - Each edge: shift the next magnitude MSB into the partial remainder (DIVISOR_WIDTH+1 bits).
  - If partial remainder >= divisor, subtract and shift quotient bit 1, else shift 0. Decrement counter.
  - After DIVIDEND_WIDTH edges, go to FIX.
  - Divisor 0 also runs the full CALC sequence (results discarded), keeping latency constant.
- FIX (one edge): apply sign, saturate to [-2^(QW-1), 2^(QW-1)-1], set flags, go to OUT.
  - Divisor 0: quotient=+2^(QW-1)-1 if dividend>=0, else -2^(QW-1); remainder=0; div_zero=1, ovf=0.
  - Negative, magnitude > 2^(QW-1): quotient=-2^(QW-1), ovf=1. A magnitude of exactly 2^(QW-1) is legal, ovf=0.
  - Positive, magnitude > 2^(QW-1)-1: quotient=2^(QW-1)-1, ovf=1.
  - Remainder is always the true signed remainder (negated if the dividend is negative), including when ovf=1.
- OUT:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE; out_valid=0 the next cycle.
  - Flags and quotient are held until the next FIX.
- Latency: accept edge at cycle 0, out_valid high after edge DIVIDEND_WIDTH+1 (27 by default).
- No accept in the same cycle as output handshake. Minimum initiation interval is DIVIDEND_WIDTH+3 cycles.
- in_valid while not IDLE is ignored; operand ports are don't-care outside the accept edge.
- Reset asserted mid-CALC/FIX/OUT aborts the operation. No result is emitted, and the block returns to its reset values.

Test Plan:
- Basic: dividend=1000, divisor=7, out_ready=1 -> out_valid exactly 27 cycles after accept; quotient=142, remainder=6, ovf=0, div_zero=0.
- Negative/limits:
  - dividend=-1000, divisor=7 -> quotient=-142, remainder=-6.
  - dividend=-33554432, divisor=255 -> quotient=-131586, remainder=-2, ovf=0.
- Saturation:
  - 33554431/1 -> quotient=262143, ovf=1.
  - -262144/1 -> quotient=-262144, ovf=0.
  - -262145/1 -> quotient=-262144, ovf=1, remainder=0.
- Divide by zero:
  - 5/0 -> quotient=262143, div_zero=1, remainder=0, latency 27.
  - -5/0 -> quotient=-262144, div_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in OUT while driving in_valid=1 with new operands -> outputs stable, in_ready=0, no accept. Release -> one handshake, then in_ready=1 and the next operands are accepted.
- Reset mid-op: pull ap_rst_n low 10 cycles after accept -> out_valid=0 and outputs zeroed immediately (async). After release, 1000/7 completes correctly with 142/6.

Source files
------------

// File: rtl/fir_hls_sdiv_26s_8ns_19_seq_if.sv
// ---------------------------------------------------------------------------
// fir_hls_sdiv_26s_8ns_19_seq_if
//
// Purpose: groups the operand and result handshakes of the sequential
// signed-by-unsigned divider into one bundle. The producer of operands and
// consumer of results is the master; the divider itself is the slave.
//
// Signals:
//   in_valid   master->slave  operands valid
//   in_ready   slave->master  divider can accept operands
//   dividend   master->slave  signed two's-complement dividend
//   divisor    master->slave  unsigned divisor
//   out_valid  slave->master  result valid
//   out_ready  master->slave  consumer accepts result
//   quotient   slave->master  signed quotient, truncated toward zero, saturated
//   remainder  slave->master  signed remainder, sign follows the dividend
//   ovf        slave->master  quotient was saturated (divisor nonzero)
//   div_zero   slave->master  divisor was zero
// ---------------------------------------------------------------------------
interface fir_hls_sdiv_26s_8ns_19_seq_if #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int QUOTIENT_WIDTH = 19
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [QUOTIENT_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH:0]    remainder;
  logic                      ovf;
  logic                      div_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  ovf,
    input  div_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output ovf,
    output div_zero
  );

endinterface

// File: rtl/fir_hls_sdiv_26s_8ns_19_seq.sv
// ---------------------------------------------------------------------------
// fir_hls_sdiv_26s_8ns_19_seq
//
// Purpose: sequential restoring divider that normalises the FIR accumulator
// gain. A signed DIVIDEND_WIDTH-bit dividend is divided by an unsigned
// DIVISOR_WIDTH-bit divisor, one quotient bit per clock, with a constant
// latency of DIVIDEND_WIDTH+1 clocks from accept to out_valid. The quotient
// is truncated toward zero and saturated to a QUOTIENT_WIDTH-bit signed
// range; the remainder carries the sign of the dividend.
//
// Ports:
//   ap_clk    clock, all state changes on the rising edge
//   ap_rst_n  asynchronous active-low reset
//   bus       slave side of fir_hls_sdiv_26s_8ns_19_seq_if carrying the
//             operand handshake (in_valid/in_ready/dividend/divisor) and the
//             result handshake (out_valid/out_ready/quotient/remainder/
//             ovf/div_zero)
// ---------------------------------------------------------------------------
module fir_hls_sdiv_26s_8ns_19_seq #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int QUOTIENT_WIDTH = 19
) (
  input logic                          ap_clk,
  input logic                          ap_rst_n,
  fir_hls_sdiv_26s_8ns_19_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  // Largest positive quotient magnitude, and largest negative magnitude
  // (one more, since -2^(QW-1) is representable).
  localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT =
    DIVIDEND_WIDTH'((64'd1 << (QUOTIENT_WIDTH - 1)) - 64'd1);
  localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT =
    DIVIDEND_WIDTH'(64'd1 << (QUOTIENT_WIDTH - 1));

  localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    OUT
  } state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic [DIVIDEND_WIDTH-1:0] mag_q, mag_d;
  logic [DIVISOR_WIDTH:0]    prem_q, prem_d;
  logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  dvsr_q, dvsr_d;
  logic                      neg_q, neg_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [QUOTIENT_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIVISOR_WIDTH:0]    remainder_q, remainder_d;
  logic                      ovf_q, ovf_d;
  logic                      div_zero_q, div_zero_d;

  // Restoring step: the partial remainder is always below the divisor, so
  // only its low DIVISOR_WIDTH bits are needed before shifting in the next
  // dividend magnitude bit.
  logic [DIVISOR_WIDTH:0] trial;
  logic [DIVISOR_WIDTH:0] diff;
  logic                   fits;

  assign trial = {prem_q[DIVISOR_WIDTH-1:0], mag_q[DIVIDEND_WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr_q};
  assign fits  = (trial >= {1'b0, dvsr_q});

  // in_ready is registered so that it stays low while reset is asserted and
  // rises on the first clock after release.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == OUT);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;
  assign bus.div_zero  = div_zero_q;

  // State and datapath registers; everything returns to zero/IDLE on reset,
  // which also discards any division in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mag_q       <= '0;
      prem_q      <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mag_q       <= mag_d;
      prem_q      <= prem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Next-state and datapath logic. Divide-by-zero still walks through every
  // CALC step so the latency never depends on the operands; its iteration
  // results are simply ignored in FIX.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    prem_d      = prem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          neg_d  = bus.dividend[DIVIDEND_WIDTH-1];
          // The magnitude of the most negative dividend still fits unsigned.
          mag_d  = bus.dividend[DIVIDEND_WIDTH-1] ? -bus.dividend : bus.dividend;
          dvsr_d = bus.divisor;
          prem_d = '0;
          quot_d = '0;
          cnt_d  = CNT_W'(DIVIDEND_WIDTH);
          state_d = CALC;
        end
      end

      CALC: begin
        mag_d = {mag_q[DIVIDEND_WIDTH-2:0], 1'b0};
        if (fits) begin
          prem_d = diff;
          quot_d = {quot_q[DIVIDEND_WIDTH-2:0], 1'b1};
        end else begin
          prem_d = trial;
          quot_d = {quot_q[DIVIDEND_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = OUT;
        if (dvsr_q == '0) begin
          quotient_d  = neg_q ? Q_MIN : Q_MAX;
          remainder_d = '0;
          div_zero_d  = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          div_zero_d  = 1'b0;
          remainder_d = neg_q ? -prem_q : prem_q;
          if (neg_q) begin
            if (quot_q > NEG_LIMIT) begin
              quotient_d = Q_MIN;
              ovf_d      = 1'b1;
            end else begin
              quotient_d = -quot_q[QUOTIENT_WIDTH-1:0];
              ovf_d      = 1'b0;
            end
          end else begin
            if (quot_q > POS_LIMIT) begin
              quotient_d = Q_MAX;
              ovf_d      = 1'b1;
            end else begin
              quotient_d = quot_q[QUOTIENT_WIDTH-1:0];
              ovf_d      = 1'b0;
            end
          end
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

endmodule
